// File: rtl/syn_rst_seq.sv
// syn_rst_seq: PLL-lock-qualified reset sequencer; holds all domains in reset, then releases them one by one.
module syn_rst_seq #(
   parameter int NUM_DOMAINS    = 4,
   parameter int LOCK_DEBOUNCE  = 4,
   parameter int HOLD_CYCLES    = 16,
   parameter int STAGGER_CYCLES = 8,
   parameter int CNT_W          = 8
) (
   input  logic                   clk_ir,
   input  logic                   rst_sync_ir,
   input  logic                   pll_lock_ia,
   input  logic                   sw_rst_req_ir,
   output logic [NUM_DOMAINS-1:0] rst_sync_l_o,
   output logic                   rst_done_o,
   output logic [1:0]             fsm_state_o
);
   typedef enum logic [1:0] {WAIT_LOCK, HOLD, RELEASE, DONE} state_t;
   state_t state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [NUM_DOMAINS-1:0] rst_l_nxt, shifted;
   logic lock_m, lock_s, abort, done_nxt;
   assign fsm_state_o = state;
   // released domains form a low-index prefix, so releasing the next one is a shift-in of a 1
   assign shifted = NUM_DOMAINS'({rst_sync_l_o, 1'b1});
   assign abort = sw_rst_req_ir | (~lock_s & (state != WAIT_LOCK));
   always_ff @(posedge clk_ir) begin
      if (rst_sync_ir) begin
         lock_m       <= 1'b0;
         lock_s       <= 1'b0;
         state        <= WAIT_LOCK;
         cnt          <= '0;
         rst_sync_l_o <= '0;
         rst_done_o   <= 1'b0;
      end else begin
         lock_m       <= pll_lock_ia;
         lock_s       <= lock_m;
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         rst_sync_l_o <= rst_l_nxt;
         rst_done_o   <= done_nxt;
      end
   end
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      rst_l_nxt = rst_sync_l_o;
      done_nxt  = state == DONE;
      if (abort) begin
         state_nxt = WAIT_LOCK;
         cnt_nxt   = '0;
         rst_l_nxt = '0;
         done_nxt  = 1'b0;
      end else begin
         case (state)
            WAIT_LOCK: begin
               cnt_nxt = lock_s ? cnt + 1'b1 : '0;
               if (lock_s && cnt == CNT_W'(LOCK_DEBOUNCE - 1)) begin
                  state_nxt = HOLD;
                  cnt_nxt   = '0;
               end
            end
            HOLD: begin
               if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                  rst_l_nxt = shifted;
                  state_nxt = shifted[NUM_DOMAINS-1] ? DONE : RELEASE;
                  cnt_nxt   = '0;
               end
            end
            RELEASE: begin
               if (cnt == CNT_W'(STAGGER_CYCLES - 1)) begin
                  rst_l_nxt = shifted;
                  state_nxt = shifted[NUM_DOMAINS-1] ? DONE : RELEASE;
                  cnt_nxt   = '0;
               end
            end
            default: cnt_nxt = cnt;
         endcase
      end
   end
endmodule

// File: tb/tb_syn_rst_seq.sv
// tb_syn_rst_seq: random lock/sw/reset stimulus against an elapsed-good-cycles reference model.
module tb_syn_rst_seq;
   logic clk_ir = 1'b0, rst_sync_ir = 1'b1, pll_lock_ia = 1'b0, sw_rst_req_ir = 1'b0;
   logic [3:0] rst_l_a;
   logic [0:0] rst_l_b;
   logic       done_a, done_b;
   logic [1:0] st_a, st_b;
   int n_chk = 0, n_pass = 0, t = 0;
   bit m1 = 0, m2 = 0;
   always #5 clk_ir = ~clk_ir;
   syn_rst_seq dut_a (
      .clk_ir(clk_ir), .rst_sync_ir(rst_sync_ir), .pll_lock_ia(pll_lock_ia),
      .sw_rst_req_ir(sw_rst_req_ir), .rst_sync_l_o(rst_l_a), .rst_done_o(done_a), .fsm_state_o(st_a)
   );
   syn_rst_seq #(.NUM_DOMAINS(1), .LOCK_DEBOUNCE(1), .HOLD_CYCLES(1)) dut_b (
      .clk_ir(clk_ir), .rst_sync_ir(rst_sync_ir), .pll_lock_ia(pll_lock_ia),
      .sw_rst_req_ir(sw_rst_req_ir), .rst_sync_l_o(rst_l_b), .rst_done_o(done_b), .fsm_state_o(st_b)
   );
   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask
   function automatic int n_rel(input int tt, input int n, input int ld, input int hc, input int sc);
      int r;
      if (tt < ld + hc) return 0;
      r = (tt - ld - hc) / sc + 1;
      return r > n ? n : r;
   endfunction
   task automatic check_dut(input string tag, input int n, input int ld, input int hc, input int sc,
                            input int mask, input int done, input int st);
      int r;
      r = n_rel(t, n, ld, hc, sc);
      check({tag, "_rst_l"}, mask, (1 << r) - 1);
      check({tag, "_done"}, done, (t > ld + hc + (n - 1) * sc) ? 1 : 0);
      check({tag, "_state"}, st, t < ld ? 0 : t < ld + hc ? 1 : r < n ? 2 : 3);
   endtask
   // t counts consecutive edges with a synchronized lock and no abort; every output follows from it
   task automatic step(input bit rst, input bit lock, input bit sw);
      bit ls;
      rst_sync_ir = rst;
      pll_lock_ia = lock;
      sw_rst_req_ir = sw;
      @(posedge clk_ir);
      ls = m2;
      if (rst) begin
         m1 = 0;
         m2 = 0;
         t = 0;
      end else begin
         t = (sw || !ls) ? 0 : t + 1;
         m2 = m1;
         m1 = lock;
      end
      #1;
      check_dut("a", 4, 4, 16, 8, int'(rst_l_a), int'(done_a), int'(st_a));
      check_dut("b", 1, 1, 1, 8, int'(rst_l_b), int'(done_b), int'(st_b));
   endtask
   initial begin
      repeat (3) step(1, 1, 0);
      repeat (60) step(0, 1, 0);
      repeat (4) step(0, 0, 0);
      repeat (40) step(0, 1, 0);
      step(0, 1, 1);
      repeat (60) step(0, 1, 0);
      repeat (38) step(0, 1, 0);
      step(1, 1, 1);
      repeat (60) step(0, 1, 0);
      repeat (4) step(0, 1, 0);
      step(0, 0, 0);
      repeat (60) step(0, 1, 0);
      for (int s = 0; s < 60; s++) begin
         int len;
         len = $urandom_range(5, 90);
         for (int i = 0; i < len; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 99) != 0, $urandom_range(0, 89) == 0);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
